// File: rtl/ux607_mrom_pkg.sv
// Shared definitions for the boot mask-ROM: opcode fields, the ROM content
// function and the response entry carried through the response buffer.
package ux607_mrom_pkg;

    localparam int MAX_DW = 64;

    localparam logic [11:0] LUI_T0  = 12'h2B7;
    localparam logic [19:0] ADDI_T0 = 20'h28293;
    localparam logic [31:0] JALR_T0 = 32'h0002_8067;

    typedef struct packed {
        logic              err;
        logic [MAX_DW-1:0] rdata;
    } rsp_entry_t;

    // Word idx of the jump-to-boot_addr sequence. The +0x800 rounding on the
    // upper immediate compensates for addi sign-extending a lo12 >= 0x800.
    function automatic logic [31:0] rom_word(input logic [31:0] idx,
                                             input logic [31:0] boot_addr);
        logic [19:0] hi20;
        hi20 = 20'((boot_addr + 32'h0000_0800) >> 12);
        case (idx)
            32'd0:   rom_word = {hi20, LUI_T0};
            32'd1:   rom_word = {boot_addr[11:0], ADDI_T0};
            32'd2:   rom_word = JALR_T0;
            default: rom_word = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/ux607_mrom_rsp_buf.sv
// Response buffer between the ROM decode and the ICB response channel.
// Default: one response register, ready = ~valid | out_ready.
// With UX607_MROM_ICB_SKID_EN defined: a 2-entry FIFO whose in_ready is a
// register (~full) so the response-side ready never reaches the command side.
module ux607_mrom_rsp_buf #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef UX607_MROM_ICB_SKID_EN

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    // Occupancy after this edge; push+pop together leaves it unchanged
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && pop) begin
            count_nxt = count - 2'd1;
        end
    end

    // Storage, wrap-around pointers and the registered not-full ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
        end
    end

`else

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Single slot: a new accept overwrites the slot in the same edge it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/ux607_mrom_icb.sv
// Boot mask-ROM with an ICB slave port. Contents are a lui/addi/jalr jump to
// BOOT_ADDR; writes and out-of-range reads answer err=1 with zero data.
// Optional feature macro: UX607_MROM_ICB_SKID_EN (2-entry response FIFO).
module ux607_mrom_icb #(
    parameter int          AW        = 12,
    parameter int          DW        = 32,
    parameter int          DP        = 1024,
    parameter logic [31:0] BOOT_ADDR = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [DW-1:0] icb_rsp_rdata,
    output logic          icb_rsp_err
);

    import ux607_mrom_pkg::*;

    logic [31:0] word_idx;
    logic        in_range;
    rsp_entry_t  rsp_d;
    rsp_entry_t  rsp_q;
    logic        unused_inputs;

    // Write data, byte mask and sub-word address bits carry no meaning here
    assign unused_inputs = ^{icb_cmd_wdata, icb_cmd_wmask, icb_cmd_addr[2:0], rsp_q.rdata};

    // ROM decode: 32-bit word index, range check and response entry
    always_comb begin
        word_idx = 32'h0;
        in_range = 1'b0;
        rsp_d    = '0;
        if (DW == 64) begin
            word_idx = 32'(icb_cmd_addr[AW-1:3]) << 1;
        end else begin
            word_idx = 32'(icb_cmd_addr[AW-1:2]);
        end
        in_range = (word_idx < 32'(DP));
        if (icb_cmd_read && in_range) begin
            rsp_d.err = 1'b0;
            if (DW == 64) begin
                rsp_d.rdata = {rom_word(word_idx + 32'd1, BOOT_ADDR),
                               rom_word(word_idx, BOOT_ADDR)};
            end else begin
                rsp_d.rdata = {32'h0, rom_word(word_idx, BOOT_ADDR)};
            end
        end else begin
            rsp_d.err   = 1'b1;
            rsp_d.rdata = '0;
        end
    end

    ux607_mrom_rsp_buf #(
        .W ($bits(rsp_entry_t))
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (icb_cmd_valid),
        .in_ready  (icb_cmd_ready),
        .in_data   (rsp_d),
        .out_valid (icb_rsp_valid),
        .out_ready (icb_rsp_ready),
        .out_data  (rsp_q)
    );

    assign icb_rsp_rdata = rsp_q.rdata[DW-1:0];
    assign icb_rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_ux607_mrom_icb.sv
// Bench for ux607_mrom_icb: three ROM configurations driven by one shared
// command/response handshake, checked against a queue-based reference model.
module tb_ux607_mrom_icb;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [12:0] cmd_addr;
    logic        cmd_read;
    logic        rsp_ready;
    logic [31:0] wdata32;
    logic [3:0]  wmask4;
    logic [63:0] wdata64;
    logic [7:0]  wmask8;

    logic        cmd_ready0, cmd_ready1, cmd_ready2;
    logic        rsp_valid0, rsp_valid1, rsp_valid2;
    logic [31:0] rdata0, rdata1;
    logic [63:0] rdata2;
    logic        err0, err1, err2;

    int nVectors;
    int nMiscompares;
    int dutAccepts;

    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [64:0] q2[$];

    ux607_mrom_icb #(.AW(13), .DW(32), .DP(1024), .BOOT_ADDR(32'h8000_0000)) u_dut0 (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready0),
        .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
        .icb_cmd_wdata(wdata32), .icb_cmd_wmask(wmask4),
        .icb_rsp_valid(rsp_valid0), .icb_rsp_ready(rsp_ready),
        .icb_rsp_rdata(rdata0), .icb_rsp_err(err0)
    );

    ux607_mrom_icb #(.AW(12), .DW(32), .DP(1024), .BOOT_ADDR(32'h8000_0800)) u_dut1 (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready1),
        .icb_cmd_addr(cmd_addr[11:0]), .icb_cmd_read(cmd_read),
        .icb_cmd_wdata(wdata32), .icb_cmd_wmask(wmask4),
        .icb_rsp_valid(rsp_valid1), .icb_rsp_ready(rsp_ready),
        .icb_rsp_rdata(rdata1), .icb_rsp_err(err1)
    );

    ux607_mrom_icb #(.AW(13), .DW(64), .DP(1024), .BOOT_ADDR(32'h2040_0000)) u_dut2 (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready2),
        .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
        .icb_cmd_wdata(wdata64), .icb_cmd_wmask(wmask8),
        .icb_rsp_valid(rsp_valid2), .icb_rsp_ready(rsp_ready),
        .icb_rsp_rdata(rdata2), .icb_rsp_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction i of a jump to boot, built from the encoding rules directly
    function automatic logic [31:0] refWord(input int unsigned i, input logic [31:0] boot);
        if (i == 0) return (((boot + 32'h800) >> 12) << 12) | 32'h2B7;
        if (i == 1) return ((boot & 32'hFFF) << 20) | 32'h28293;
        if (i == 2) return 32'h0002_8067;
        return 32'h0;
    endfunction

    // Expected {err, rdata64} for configuration cfg (0, 1, 2 as instantiated)
    function automatic logic [64:0] refRsp(input int cfg, input logic [12:0] addr, input logic rd);
        int unsigned aw, dw, a, i;
        logic [31:0] boot;
        case (cfg)
            0:       begin aw = 13; dw = 32; boot = 32'h8000_0000; end
            1:       begin aw = 12; dw = 32; boot = 32'h8000_0800; end
            default: begin aw = 13; dw = 64; boot = 32'h2040_0000; end
        endcase
        a = int'(addr) % (1 << aw);
        if (!rd) return {1'b1, 64'h0};
        if (dw == 32) begin
            i = a / 4;
            if (i >= 1024) return {1'b1, 64'h0};
            return {1'b0, 32'h0, refWord(i, boot)};
        end
        i = (a / 8) * 2;
        if (i >= 1024) return {1'b1, 64'h0};
        return {1'b0, refWord(i + 1, boot), refWord(i, boot)};
    endfunction

    // Command-side ready expected from the number of outstanding responses
    function automatic logic modelReady(input logic rr);
`ifdef UX607_MROM_ICB_SKID_EN
        return (q0.size() < 2);
`else
        return (q0.size() == 0) || rr;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check just after, update the model at posedge
    task automatic applyStimulus(input logic v, input logic [12:0] a, input logic rd, input logic rr);
        logic expRdy;
        @(negedge clk);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_read  = rd;
        rsp_ready = rr;
        #1;
        expRdy = modelReady(rr);
        if (v && cmd_ready0) dutAccepts++;
        checkOutput("cmd_ready0", 65'(cmd_ready0), 65'(expRdy));
        checkOutput("cmd_ready1", 65'(cmd_ready1), 65'(expRdy));
        checkOutput("cmd_ready2", 65'(cmd_ready2), 65'(expRdy));
        checkOutput("rsp_valid0", 65'(rsp_valid0), 65'(q0.size() != 0));
        checkOutput("rsp_valid1", 65'(rsp_valid1), 65'(q1.size() != 0));
        checkOutput("rsp_valid2", 65'(rsp_valid2), 65'(q2.size() != 0));
        if (q0.size() != 0) checkOutput("rsp0", {err0, 32'h0, rdata0}, q0[0]);
        if (q1.size() != 0) checkOutput("rsp1", {err1, 32'h0, rdata1}, q1[0]);
        if (q2.size() != 0) checkOutput("rsp2", {err2, rdata2}, q2[0]);
        @(posedge clk);
        if (rr && q0.size() != 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            void'(q2.pop_front());
        end
        if (v && expRdy) begin
            q0.push_back(refRsp(0, a, rd));
            q1.push_back(refRsp(1, a, rd));
            q2.push_back(refRsp(2, a, rd));
        end
    endtask

    initial begin
        logic [12:0] ra;
        nVectors     = 0;
        nMiscompares = 0;
        dutAccepts   = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_read  = 1'b1;
        rsp_ready = 1'b1;
        wdata32   = 32'hDEAD_BEEF;
        wmask4    = 4'hF;
        wdata64   = 64'hCAFE_F00D_DEAD_BEEF;
        wmask8    = 8'hFF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ready0", 65'(cmd_ready0), 65'd1);
        checkOutput("rst_ready2", 65'(cmd_ready2), 65'd1);
        checkOutput("rst_valid0", 65'(rsp_valid0), 65'd0);
        checkOutput("rst_valid1", 65'(rsp_valid1), 65'd0);
        checkOutput("rst_rsp0", {err0, 32'h0, rdata0}, 65'd0);
        checkOutput("rst_rsp2", {err2, rdata2}, 65'd0);
        rst = 1'b0;

        // Directed reads with one-cycle latency and literal contents
        applyStimulus(1'b1, 13'h0, 1'b1, 1'b1);
        #1;
        checkOutput("lat_valid0", 65'(rsp_valid0), 65'd1);
        checkOutput("w0_dut0", {err0, 32'h0, rdata0}, {1'b0, 64'h0000_0000_8000_02B7});
        checkOutput("w0_dut1", {err1, 32'h0, rdata1}, {1'b0, 64'h0000_0000_8000_12B7});
        checkOutput("w0_dut2", {err2, rdata2}, {1'b0, 64'h0002_8293_2040_02B7});
        applyStimulus(1'b1, 13'h4, 1'b1, 1'b1);
        #1;
        checkOutput("w1_dut0", {err0, 32'h0, rdata0}, {1'b0, 64'h0000_0000_0002_8293});
        checkOutput("w1_dut1", {err1, 32'h0, rdata1}, {1'b0, 64'h0000_0000_8002_8293});
        checkOutput("w1_dut2", {err2, rdata2}, {1'b0, 64'h0002_8293_2040_02B7});
        applyStimulus(1'b1, 13'h8, 1'b1, 1'b1);
        #1;
        checkOutput("w2_dut0", {err0, 32'h0, rdata0}, {1'b0, 64'h0000_0000_0002_8067});
        checkOutput("w2_dut2", {err2, rdata2}, {1'b0, 64'h0000_0000_0002_8067});
        applyStimulus(1'b1, 13'hC, 1'b1, 1'b1);
        #1;
        checkOutput("w3_dut0", {err0, 32'h0, rdata0}, 65'd0);
        checkOutput("w3_dut1", {err1, 32'h0, rdata1}, 65'd0);

        // Write and out-of-range read
        applyStimulus(1'b1, 13'h0, 1'b0, 1'b1);
        #1;
        checkOutput("wr_dut0", {err0, 32'h0, rdata0}, {1'b1, 64'h0});
        checkOutput("wr_dut2", {err2, rdata2}, {1'b1, 64'h0});
        applyStimulus(1'b1, 13'h1000, 1'b1, 1'b1);
        #1;
        checkOutput("oor_dut0", {err0, 32'h0, rdata0}, {1'b1, 64'h0});
        checkOutput("alias_dut1", {err1, 32'h0, rdata1}, {1'b0, 64'h0000_0000_8000_12B7});
        checkOutput("oor_dut2", {err2, rdata2}, {1'b1, 64'h0});
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);

        // Back-pressure: response held for 5 cycles during back-to-back reads
        dutAccepts = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 13'(i * 4), 1'b1, 1'b0);
        end
`ifdef UX607_MROM_ICB_SKID_EN
        checkOutput("hold_accepts", 65'(dutAccepts), 65'd2);
`else
        checkOutput("hold_accepts", 65'(dutAccepts), 65'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 13'($urandom_range(0, 15));
                1:       ra = 13'h1000 + 13'($urandom_range(0, 15));
                2:       ra = 13'h0FF8 + 13'($urandom_range(0, 15));
                default: ra = 13'($urandom);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, ra, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);

        // Reset while a response is pending discards it
        applyStimulus(1'b1, 13'h4, 1'b1, 1'b0);
        #1;
        checkOutput("pend_valid0", 65'(rsp_valid0), 65'd1);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checkOutput("mid_rst_valid0", 65'(rsp_valid0), 65'd0);
        checkOutput("mid_rst_valid2", 65'(rsp_valid2), 65'd0);
        checkOutput("mid_rst_ready0", 65'(cmd_ready0), 65'd1);
        checkOutput("mid_rst_rsp0", {err0, 32'h0, rdata0}, 65'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
